// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator for one port of the byte-addressed data RAM.
// Accepts one request per handshake. It issues the sized RAM access and waits out the
// registered read latency. It then returns extended load data or a store completion.
// Illegal or out-of-range requests get an error response and never reach the RAM.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses become errors).
module lsu_mem_port #(
    parameter int unsigned MEM_DEPTH      = 4096,
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [2:0]                i_req_funct3,
    input  logic [31:0]               i_req_addr,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [31:0]               o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                      o_mem_we,
    output logic [1:0]                o_mem_size,
    output logic [31:0]               o_mem_din,
    input  logic [31:0]               i_mem_dout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                    state_q, state_d;
    logic                      we_q;
    logic [2:0]                funct3_q;
    logic [31:0]               rsp_rdata_q;
    logic                      rsp_err_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [1:0]                mem_size_q;
    logic [31:0]               mem_din_q;

    logic                      accept;
    logic                      illegal;
    logic [2:0]                bytes;
    logic [32:0]               end_addr;
    logic [31:0]               load_ext;

    assign accept = (state_q == StIdle) && i_req_valid && !i_rst;

    // Classify the incoming request; the range check is done in 33 bits so nothing wraps.
    always_comb begin
        case (i_req_funct3[1:0])
            2'b00:   bytes = 3'd1;
            2'b01:   bytes = 3'd2;
            default: bytes = 3'd4;
        endcase
        end_addr = {1'b0, i_req_addr} + {30'd0, bytes};
        if (i_req_we) begin
            illegal = (i_req_funct3 > 3'd2);
        end else begin
            illegal = (i_req_funct3 == 3'd3) || (i_req_funct3 == 3'd6) ||
                      (i_req_funct3 == 3'd7);
        end
        if (end_addr > 33'(MEM_DEPTH)) begin
            illegal = 1'b1;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
            (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
`endif
    end

    // Extend the RAM read data according to the captured load type.
    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{i_mem_dout[7]}}, i_mem_dout[7:0]};
            3'b001:  load_ext = {{16{i_mem_dout[15]}}, i_mem_dout[15:0]};
            3'b100:  load_ext = {24'd0, i_mem_dout[7:0]};
            3'b101:  load_ext = {16'd0, i_mem_dout[15:0]};
            default: load_ext = i_mem_dout;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake / write-enable outputs.
    always_comb begin
        state_d     = state_q;
        o_req_ready = (state_q == StIdle) && !i_rst;
        o_rsp_valid = (state_q == StResp);
        // Gated by reset in the same cycle so an in-flight store is dropped.
        o_mem_we    = (state_q == StIssue) && we_q && !i_rst;
        unique case (state_q)
            StIdle:  if (i_req_valid) state_d = illegal ? StResp : StIssue;
            StIssue: state_d = we_q ? StResp : StWait;
            StWait:  state_d = StResp;
            StResp:  if (i_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, RAM port registers and response data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_size_q  <= 2'd0;
            mem_din_q   <= 32'd0;
        end else begin
            if (accept) begin
                we_q        <= i_req_we;
                funct3_q    <= i_req_funct3;
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= illegal;
                // RAM port only moves for accesses that will actually be issued.
                if (!illegal) begin
                    mem_addr_q <= i_req_addr[MEM_ADDR_WIDTH-1:0];
                    mem_size_q <= i_req_funct3[1:0];
                    mem_din_q  <= i_req_wdata;
                end
            end
            if (state_q == StWait) begin
                rsp_rdata_q <= load_ext;
            end
        end
    end

    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_size  = mem_size_q;
    assign o_mem_din   = mem_din_q;

endmodule
